// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle two's-complement add/sub, DIGIT bits per clock, LSB first,
// with a start/busy/done handshake and carry, overflow, zero and negative flags.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_q, acc_d, sum_q, sum_d, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sub_q, sub_d, c_q, c_d;
  logic busy_q, busy_d, done_q, done_d, carry_q, carry_d;
  logic overflow_q, overflow_d, zero_q, zero_d, negative_q, negative_d;
  logic [DIGIT-1:0] bd;
  logic [DIGIT:0] d;
  logic accept, run, fin;
  always_comb begin
    accept = (state_q == IDLE) && start;
    run = state_q == RUN;
    fin = run && (cnt_q == CW'(N - 1));
    bd = b_sh_q[DIGIT-1:0] ^ {DIGIT{sub_q}};
    d = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, bd} + (DIGIT+1)'(c_q);
    // new digit enters at the top; after N shifts every digit sits in its own position
    res = (acc_q >> DIGIT) | (WIDTH'(d[DIGIT-1:0]) << (WIDTH - DIGIT));
    state_d = accept ? RUN : fin ? IDLE : state_q;
    a_sh_d = accept ? a : run ? a_sh_q >> DIGIT : a_sh_q;
    b_sh_d = accept ? b : run ? b_sh_q >> DIGIT : b_sh_q;
    sub_d = accept ? sub : sub_q;
    c_d = accept ? sub : run ? d[DIGIT] : c_q;
    cnt_d = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    acc_d = accept ? '0 : run ? res : acc_q;
    busy_d = accept ? 1'b1 : fin ? 1'b0 : busy_q;
    done_d = fin;
    sum_d = fin ? res : sum_q;
    carry_d = fin ? d[DIGIT] : carry_q;
    overflow_d = fin ? (a_sh_q[DIGIT-1] == bd[DIGIT-1]) && (res[WIDTH-1] != a_sh_q[DIGIT-1]) : overflow_q;
    zero_d = fin ? (res == '0) : zero_q;
    negative_d = fin ? res[WIDTH-1] : negative_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q <= '0;
      sub_q <= 1'b0;
      c_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q <= '0;
      carry_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q <= acc_d;
      sub_q <= sub_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      overflow_q <= overflow_d;
      zero_q <= zero_d;
      negative_q <= negative_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum = sum_q;
  assign carry = carry_q;
  assign overflow = overflow_q;
  assign zero = zero_q;
  assign negative = negative_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and model-checked tests for serial_addsub at
// WIDTH=8/DIGIT=2 and WIDTH=16 with DIGIT 1, 4 and 16.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  logic start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic busy8, done8, c8, o8, z8, n8;
  serial_addsub #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(s8), .carry(c8), .overflow(o8), .zero(z8), .negative(n8)
  );

  logic start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] s16 [3];
  logic busy16 [3], done16 [3], c16 [3], o16 [3], z16 [3], n16 [3];
  int lat16 [3] = '{16, 4, 1};
  serial_addsub #(.WIDTH(16), .DIGIT(1)) u16_1 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16[0]), .done(done16[0]), .sum(s16[0]), .carry(c16[0]), .overflow(o16[0]), .zero(z16[0]), .negative(n16[0])
  );
  serial_addsub #(.WIDTH(16), .DIGIT(4)) u16_4 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16[1]), .done(done16[1]), .sum(s16[1]), .carry(c16[1]), .overflow(o16[1]), .zero(z16[1]), .negative(n16[1])
  );
  serial_addsub #(.WIDTH(16), .DIGIT(16)) u16_16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16[2]), .done(done16[2]), .sum(s16[2]), .carry(c16[2]), .overflow(o16[2]), .zero(z16[2]), .negative(n16[2])
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, s8, c8, o8, z8, n8} !== 14'd0) begin
      errors++;
      $display("FAIL reset8 got=%h want=0", {busy8, done8, s8, c8, o8, z8, n8});
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({busy16[j], done16[j], s16[j], c16[j], o16[j], z16[j], n16[j]} !== 22'd0) begin
        errors++;
        $display("FAIL reset16[%0d] got=%h want=0", j, {busy16[j], done16[j], s16[j], c16[j], o16[j], z16[j], n16[j]});
      end
    end
    rst_n = 1'b1;
  endtask

  // Called at a negedge; starting in the done cycle of the previous op exercises back-to-back issue.
  task automatic op8(input logic [7:0] ia, ib, input logic is, input logic [7:0] es,
                     input logic ec, eo, ez, en, input string nm);
    int lat, bc;
    a8 = ia; b8 = ib; sub8 = is; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got=%b want=0", nm, done8);
    end
    lat = 0; bc = 0;
    while (!done8 && lat < 40) begin
      bc += int'(busy8);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || bc !== 4 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s latency got=%0d busy_cycles=%0d busy=%b want=4/4/0", nm, lat, bc, busy8);
    end
    checks++;
    if ({s8, c8, o8, z8, n8} !== {es, ec, eo, ez, en}) begin
      errors++;
      $display("FAIL %s result got=%h c%b o%b z%b n%b want=%h c%b o%b z%b n%b",
               nm, s8, c8, o8, z8, n8, es, ec, eo, ez, en);
    end
  endtask

  task automatic test_add_sub;
    @(negedge clk);
    op8(8'd100, 8'd27, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, "add_127");
    op8(8'd100, 8'd28, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
    op8(8'd5, 8'd5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "sub_zero");
    op8(8'd3, 8'd5, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, "sub_borrow");
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "add_wrap");
  endtask

  task automatic test_ignore_busy;
    int lat;
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h55;
    lat = 2;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || {s8, c8, o8, z8, n8} !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ignore_busy got lat=%0d %h c%b o%b z%b n%b want lat=4 80 c0 o1 z0 n1",
               lat, s8, c8, o8, z8, n8);
    end
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_after_done");
  endtask

  task automatic test_reset_abort;
    logic seen;
    a8 = 8'h33; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, s8, c8, o8, z8, n8} !== 14'd0) begin
      errors++;
      $display("FAIL reset_abort got=%h want=0", {busy8, done8, s8, c8, o8, z8, n8});
    end
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= done8 | busy8;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got done_or_busy=%b want=0", seen);
    end
    op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic op16(input logic [15:0] ia, ib, input logic is, input logic [15:0] es,
                      input logic ec, eo, ez, en, input string nm);
    int lat;
    int got [3];
    a16 = ia; b16 = ib; sub16 = is; start16 = 1'b1;
    got = '{-1, -1, -1};
    lat = 0;
    @(negedge clk);
    start16 = 1'b0;
    while (got[0] < 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      for (int j = 0; j < 3; j++)
        if (done16[j] && got[j] < 0) begin
          got[j] = lat;
          checks++;
          if ({s16[j], c16[j], o16[j], z16[j], n16[j]} !== {es, ec, eo, ez, en}) begin
            errors++;
            $display("FAIL %s[%0d] a=%h b=%h sub=%b got=%h c%b o%b z%b n%b want=%h c%b o%b z%b n%b",
                     nm, j, ia, ib, is, s16[j], c16[j], o16[j], z16[j], n16[j], es, ec, eo, ez, en);
          end
        end
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (got[j] !== lat16[j]) begin
        errors++;
        $display("FAIL %s[%0d] latency got=%0d want=%0d", nm, j, got[j], lat16[j]);
      end
    end
  endtask

  task automatic test_sweep;
    @(negedge clk);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "sweep_wrap");
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, "sweep_ovf");
    op16(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "sweep_subz");
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, bb, es;
    logic rs, ec;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      bb = rb ^ {16{rs}};
      {ec, es} = {1'b0, ra} + {1'b0, bb} + 17'(rs);
      op16(ra, rb, rs, es, ec, (ra[15] == bb[15]) && (es[15] != ra[15]), es == 16'h0, es[15], "rand16");
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_ignore_busy;
    test_reset_abort;
    test_sweep;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
